// File: rtl/countdown_timer.sv
// Prescaled loadable down-counter: start loads load_val, ticks every PRESCALE cycles, one-cycle tc at terminal count.
// Latency: count shows load_val one edge after start; no backpressure, pause freezes count and prescaler.
module countdown_timer #(
    parameter int N        = 8,
    parameter int PRESCALE = 50000000,
    parameter int PW       = 26
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    input  logic         auto_reload,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         busy,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [N-1:0]  ONE      = N'(1);

    state_t        state_q;
    logic [N-1:0]  count_q;
    logic [PW-1:0] presc_q;
    logic          tc_q;
    logic          tick;

    assign tick = (presc_q == PRE_LAST);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            count_q <= '0;
            presc_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                count_q <= '0;
                presc_q <= '0;
            end else if (start) begin
                presc_q <= '0;
                if (load_val == '0) begin
                    count_q <= '0;
                    tc_q    <= 1'b1;
                    state_q <= S_DONE;
                end else begin
                    count_q <= load_val;
                    state_q <= S_RUN;
                end
            end else begin
                case (state_q)
                    S_RUN: begin
                        // pause is checked before tick so a coinciding tick is dropped, not deferred
                        if (pause) begin
                            state_q <= S_PAUSED;
                        end else if (tick) begin
                            presc_q <= '0;
                            if (count_q > ONE) begin
                                count_q <= count_q - ONE;
                            end else if (count_q == ONE) begin
                                tc_q <= 1'b1;
                                if (auto_reload && (load_val != '0)) begin
                                    count_q <= load_val;
                                end else begin
                                    count_q <= '0;
                                    state_q <= S_DONE;
                                end
                            end else begin
                                state_q <= S_DONE;
                            end
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    S_PAUSED: begin
                        if (!pause) begin
                            state_q <= S_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign state = state_q;
    assign busy  = (state_q == S_RUN) || (state_q == S_PAUSED);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting, loadable, prescaled timer. It is the count-to-zero counterpart of the lab's up-counting sync-load counter, which counts up to a compare value and reloads 0.
- Counts a loaded value down to 0 at a rate set by an internal prescaler from CLOCK_50. It raises a one-cycle terminal-count pulse and either stops or auto-reloads.
- Sits between KEY/SW debounce/edge-detect logic and LED/HEX display drivers on the lab board top level.

Parameters:
- N, 8, width of count and load value.
- PRESCALE, 50000000, clk cycles per decrement; legal range ≥ 1.
- PW, 26, prescaler register width; must satisfy 2^PW ≥ PRESCALE.

Ports:
- clk  input  1  system clock (CLOCK_50); all state changes on rising edge.
- clear  input  1  asynchronous active-low reset.
- start  input  1  synchronous one-cycle pulse: load load_val and run.
- pause  input  1  synchronous level: hold the count while high.
- abort  input  1  synchronous one-cycle pulse: stop and return to IDLE.
- auto_reload  input  1  level: on reaching 0, reload load_val and keep running.
- load_val  input  N  start/reload value, sampled on start or reload only.
- count  output  N  current count, registered.
- tc  output  1  registered terminal-count pulse, exactly one cycle wide.
- busy  output  1  high in RUN or PAUSED.
- state  output  2  IDLE=0, RUN=1, PAUSED=2, DONE=3, for LED display.

Behaviour:
- Reset (clear=0, any time, async): state=IDLE, count=0, prescaler=0, tc=0, busy=0. Reset takes effect mid-run with no further tc.
- Input priority each cycle: abort > start > pause > tick.
- abort, any state: next state IDLE, count=0, prescaler=0, tc=0.
- start, any state: count←load_val, prescaler←0, next state RUN. If load_val==0: count←0, tc←1, next state DONE.
- Latency: start at edge k means count==load_val after edge k. The first decrement follows edge k+PRESCALE.
- IDLE: holds count; waits for start.
- RUN, tick definition: prescaler increments each cycle. When prescaler==PRESCALE-1, prescaler←0 and a tick occurs.
- RUN, tick with count>1: count←count-1.
- RUN, tick with count==1 and auto_reload==0: count←0, tc←1, next state DONE.
- RUN, tick with count==1 and auto_reload==1: count←load_val (sampled now), tc←1, stay RUN. A reload value of 0 instead gives count←0 and DONE.
- RUN with pause==1: next state PAUSED. Prescaler is held, no decrement, and pause wins over a same-cycle tick.
- PAUSED: count and prescaler frozen. When pause==0, next state RUN and counting resumes from the held prescaler value.
- DONE: count holds 0 and tc is low after its one-cycle pulse. start or abort exits.
- Timing of tc: tc is high in the same cycle count first shows its post-terminal value (0 or reloaded value). Otherwise tc=0.
- PRESCALE==1: a tick occurs every RUN cycle.
- busy = (state==RUN) or (state==PAUSED), registered-equivalent (decoded from the state register).
- count never underflows. Decrement happens only while count ≥ 1.

Test Plan:
- PRESCALE=4, load_val=3, start pulse -> count 3, then 2 at +4 cycles, 1 at +8, 0 at +12 with tc=1 for 1 cycle, state=DONE, busy=0.
- PRESCALE=4, load_val=2, auto_reload=1, start -> count 2,1,2,1,… every 4 cycles; tc pulses once per reload, state stays RUN.
- PRESCALE=4, load_val=5, pause high for 10 cycles starting 2 cycles after start -> count frozen at 5, state=PAUSED. After release, the first decrement occurs 2 cycles later.
- PRESCALE=1, load_val=0, start -> next cycle count=0, tc=1, state=DONE; no decrement attempted.
- RUN at count=7, same-cycle abort and start -> state=IDLE, count=0, tc=0 (abort wins). A later start with load_val=9 -> count=9, RUN.
- clear pulsed low asynchronously mid-RUN at count=4 -> count=0, state=IDLE, tc=0 immediately. No tc after clear rises.
